// File: rtl/conv33_sched.sv
// Raster-order sequencer for the 3x3 conv unit: window request, conv enable, result handoff.
// Optional stall counter output enabled by defining CONV33_SCHED_PERF_EN.
module conv33_sched #(
    parameter int unsigned IMG_W   = 28,
    parameter int unsigned IMG_H   = 28,
    parameter int unsigned STRIDE  = 1,
    parameter int unsigned COORD_W = 8,
    parameter int unsigned ADDR_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               win_req,
    input  logic               win_ack,
    output logic [COORD_W-1:0] win_row,
    output logic [COORD_W-1:0] win_col,
    output logic               conv_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_addr
`ifdef CONV33_SCHED_PERF_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);

    localparam int unsigned OW = (IMG_W - 3) / STRIDE + 1;
    localparam int unsigned OH = (IMG_H - 3) / STRIDE + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CONV,
        S_RES,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [COORD_W-1:0] row_q, row_d, col_q, col_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [COORD_W-1:0] win_row_q, win_col_q;
    logic               busy_q, done_q, win_req_q, conv_en_q, out_valid_q;
    logic               last_col, last_pos;

    assign last_col = (col_q == COORD_W'(OW - 1));
    assign last_pos = last_col && (row_q == COORD_W'(OH - 1));

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                    row_d   = '0;
                    col_d   = '0;
                    addr_d  = '0;
                end
            end
            S_REQ:  if (win_ack) state_d = S_CONV;
            S_CONV: state_d = S_RES;
            S_RES: begin
                if (out_ready) begin
                    if (last_pos) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                        addr_d  = addr_q + ADDR_W'(1);
                        if (last_col) begin
                            col_d = '0;
                            row_d = row_q + COORD_W'(1);
                        end else begin
                            col_d = col_q + COORD_W'(1);
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // abort overrides every handshake; counters are left as-is since start clears them
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            row_d   = row_q;
            col_d   = col_q;
            addr_d  = addr_q;
        end
    end

    // Outputs are registered from the next state so they align with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            addr_q      <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            win_req_q   <= 1'b0;
            conv_en_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            addr_q      <= addr_d;
            win_row_q   <= COORD_W'(32'(row_d) * STRIDE);
            win_col_q   <= COORD_W'(32'(col_d) * STRIDE);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
            win_req_q   <= (state_d == S_REQ);
            conv_en_q   <= (state_d == S_CONV);
            out_valid_q <= (state_d == S_RES);
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign win_req   = win_req_q;
    assign conv_en   = conv_en_q;
    assign out_valid = out_valid_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
    assign out_addr  = addr_q;

`ifdef CONV33_SCHED_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (start) stall_q <= '0;
        end else if (((state_q == S_REQ && !win_ack) || (state_q == S_RES && !out_ready))
                     && stall_q != '1) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_conv33_sched.sv
// Scoreboard bench for conv33_sched: three instances (5x5 s1, 5x5 s2, 28x28 s1) on shared stimulus.
module tb_conv33_sched;

    typedef struct packed {
        logic [7:0]  row;
        logic [7:0]  col;
        logic [15:0] addr;
    } exp_t;

    logic clk, rst, start, abort, win_ack, out_ready;
    logic        busy_w[3], done_w[3], req_w[3], conv_w[3], valid_w[3];
    logic [7:0]  wrow_w[3], wcol_w[3];
    logic [15:0] addr_w[3];
`ifdef CONV33_SCHED_PERF_EN
    logic [31:0] stall_w[3];
    logic [31:0] m_stall;
`endif

    int unsigned sel;
    int unsigned checks, errors;
    exp_t        exp_q[$];

    logic        m_busy, m_done, m_req, m_conv, m_valid;
    logic [7:0]  m_wrow, m_wcol;
    logic [15:0] m_addr;

    conv33_sched #(.IMG_W(5), .IMG_H(5), .STRIDE(1), .COORD_W(8), .ADDR_W(16)) u_s1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy_w[0]), .done(done_w[0]),
        .win_req(req_w[0]), .win_ack(win_ack), .win_row(wrow_w[0]), .win_col(wcol_w[0]),
        .conv_en(conv_w[0]), .out_valid(valid_w[0]), .out_ready(out_ready), .out_addr(addr_w[0])
`ifdef CONV33_SCHED_PERF_EN
        , .stall_cnt(stall_w[0])
`endif
    );

    conv33_sched #(.IMG_W(5), .IMG_H(5), .STRIDE(2), .COORD_W(8), .ADDR_W(16)) u_s2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy_w[1]), .done(done_w[1]),
        .win_req(req_w[1]), .win_ack(win_ack), .win_row(wrow_w[1]), .win_col(wcol_w[1]),
        .conv_en(conv_w[1]), .out_valid(valid_w[1]), .out_ready(out_ready), .out_addr(addr_w[1])
`ifdef CONV33_SCHED_PERF_EN
        , .stall_cnt(stall_w[1])
`endif
    );

    conv33_sched #(.IMG_W(28), .IMG_H(28), .STRIDE(1), .COORD_W(8), .ADDR_W(16)) u_big (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy_w[2]), .done(done_w[2]),
        .win_req(req_w[2]), .win_ack(win_ack), .win_row(wrow_w[2]), .win_col(wcol_w[2]),
        .conv_en(conv_w[2]), .out_valid(valid_w[2]), .out_ready(out_ready), .out_addr(addr_w[2])
`ifdef CONV33_SCHED_PERF_EN
        , .stall_cnt(stall_w[2])
`endif
    );

    assign m_busy  = busy_w[sel];
    assign m_done  = done_w[sel];
    assign m_req   = req_w[sel];
    assign m_conv  = conv_w[sel];
    assign m_valid = valid_w[sel];
    assign m_wrow  = wrow_w[sel];
    assign m_wcol  = wcol_w[sel];
    assign m_addr  = addr_w[sel];
`ifdef CONV33_SCHED_PERF_EN
    assign m_stall = stall_w[sel];
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int unsigned s);
        sel = s; rst = 1'b1; start = 1'b0; abort = 1'b0; win_ack = 1'b0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    // Drives one frame, checking window coords and addresses against the scoreboard.
    task automatic run_frame(input int unsigned ow, input int unsigned oh, input int unsigned s,
                             input bit rnd, input int unsigned ack_hold, input int unsigned rdy_hold,
                             input int unsigned spur_cyc,
                             output int unsigned done_cyc, output int unsigned nout,
                             output int unsigned req_len0, output int unsigned stall_at_done);
        int unsigned cyc, limit, nreq, ack_wait, rdy_wait;
        bit          prev_hold, prev_conv;
        logic [15:0] prev_addr;
        exp_t        e;
        exp_q.delete();
        for (int unsigned r = 0; r < oh; r++)
            for (int unsigned c = 0; c < ow; c++) begin
                e.row = 8'(r * s); e.col = 8'(c * s); e.addr = 16'(r * ow + c);
                exp_q.push_back(e);
            end
        done_cyc = 0; nout = 0; req_len0 = 0; stall_at_done = 0;
        nreq = 0; ack_wait = 0; rdy_wait = 0; prev_hold = 0; prev_conv = 0; prev_addr = '0;
        limit = 12 * ow * oh + ack_hold + rdy_hold + 50;
        start = 1'b1; win_ack = 1'b0; out_ready = 1'b0;
        step();
        start = 1'b0;
        cyc = 1;
        while (done_cyc == 0 && cyc <= limit) begin
            start = (cyc == spur_cyc);
            checks++;
            if (m_busy !== 1'b1) begin
                errors++; $display("FAIL busy_in_frame cyc=%0d got=%b exp=1", cyc, m_busy);
            end
            if (m_req) begin
                win_ack = rnd ? ($urandom_range(0, 2) != 0) : (nreq != 0 || ack_wait >= ack_hold);
                if (nreq == 0) begin req_len0++; ack_wait++; end
                if (win_ack) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++; $display("FAIL win_extra got=(%0d,%0d) exp=none", m_wrow, m_wcol);
                    end else if (m_wrow !== exp_q[0].row || m_wcol !== exp_q[0].col) begin
                        errors++; $display("FAIL win_coord got=(%0d,%0d) exp=(%0d,%0d)",
                                           m_wrow, m_wcol, exp_q[0].row, exp_q[0].col);
                    end
                    nreq++;
                end
            end else begin
                win_ack = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (m_conv) begin
                checks++;
                if (prev_conv) begin
                    errors++; $display("FAIL conv_en_width cyc=%0d got=2+ cycles exp=1", cyc);
                end
            end
            prev_conv = m_conv;
            if (m_valid) begin
                if (prev_hold) begin
                    checks++;
                    if (m_addr !== prev_addr) begin
                        errors++; $display("FAIL addr_stable got=%0d exp=%0d", m_addr, prev_addr);
                    end
                end
                out_ready = rnd ? ($urandom_range(0, 2) != 0) : (nout != 0 || rdy_wait >= rdy_hold);
                if (nout == 0) rdy_wait++;
                if (out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++; $display("FAIL out_extra got=%0d exp=none", m_addr);
                    end else begin
                        e = exp_q.pop_front();
                        if (m_addr !== e.addr) begin
                            errors++; $display("FAIL out_addr got=%0d exp=%0d", m_addr, e.addr);
                        end
                    end
                    nout++;
                end
                prev_hold = !out_ready;
                prev_addr = m_addr;
            end else begin
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                prev_hold = 0;
            end
            if (m_done) begin
                done_cyc = cyc;
`ifdef CONV33_SCHED_PERF_EN
                stall_at_done = m_stall;
`endif
            end else begin
                step();
                cyc++;
            end
        end
        start = 1'b0; win_ack = 1'b0; out_ready = 1'b0;
        checks++;
        if (done_cyc == 0) begin
            errors++; $display("FAIL frame_timeout got=no done exp=done within %0d cycles", limit);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL outputs_missing got=%0d left exp=0", exp_q.size());
        end
        step();
        checks++;
        if (m_busy !== 1'b0 || m_done !== 1'b0) begin
            errors++; $display("FAIL after_done got busy=%b done=%b exp busy=0 done=0", m_busy, m_done);
        end
    endtask

    task automatic test_reset();
        do_reset(0);
        checks++;
        if ({m_busy, m_done, m_req, m_conv, m_valid} !== 5'b0 || m_wrow !== 8'd0 ||
            m_wcol !== 8'd0 || m_addr !== 16'd0) begin
            errors++; $display("FAIL reset_outputs got=%b/%0d/%0d/%0d exp=0",
                               {m_busy, m_done, m_req, m_conv, m_valid}, m_wrow, m_wcol, m_addr);
        end
`ifdef CONV33_SCHED_PERF_EN
        checks++;
        if (m_stall !== 32'd0) begin
            errors++; $display("FAIL reset_stall got=%0d exp=0", m_stall);
        end
`endif
        abort = 1'b1; step(); abort = 1'b0;
        checks++;
        if (m_busy !== 1'b0) begin
            errors++; $display("FAIL abort_idle got busy=%b exp=0", m_busy);
        end
    endtask

    task automatic test_stride1();
        int unsigned dc, n, rl, st;
        do_reset(0);
        run_frame(3, 3, 1, 0, 0, 0, 0, dc, n, rl, st);
        checks++;
        if (n != 9) begin errors++; $display("FAIL s1_count got=%0d exp=9", n); end
        checks++;
        if (dc != 28) begin errors++; $display("FAIL s1_done_cycle got=%0d exp=28", dc); end
    endtask

    task automatic test_stride2();
        int unsigned dc, n, rl, st;
        do_reset(1);
        run_frame(2, 2, 2, 0, 0, 0, 0, dc, n, rl, st);
        checks++;
        if (n != 4) begin errors++; $display("FAIL s2_count got=%0d exp=4", n); end
        checks++;
        if (dc != 13) begin errors++; $display("FAIL s2_done_cycle got=%0d exp=13", dc); end
    endtask

    task automatic test_backpressure();
        int unsigned dc, n, rl, st;
        do_reset(0);
        run_frame(3, 3, 1, 0, 4, 3, 0, dc, n, rl, st);
        checks++;
        if (rl != 5) begin errors++; $display("FAIL bp_req_len got=%0d exp=5", rl); end
        checks++;
        if (dc != 35) begin errors++; $display("FAIL bp_done_cycle got=%0d exp=35", dc); end
`ifdef CONV33_SCHED_PERF_EN
        checks++;
        if (st != 7) begin errors++; $display("FAIL bp_stall_cnt got=%0d exp=7", st); end
`endif
    endtask

    task automatic test_abort();
        int unsigned dc, n, rl, st, dones;
        bit          found;
        do_reset(0);
        start = 1'b1; win_ack = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (m_valid && m_addr == 16'd4) found = 1;
            else step();
        end
        checks++;
        if (!found) begin errors++; $display("FAIL abort_reach_res got=not seen exp=RES addr 4"); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (m_busy !== 1'b0 || m_valid !== 1'b0 || m_req !== 1'b0) begin
            errors++; $display("FAIL abort_idle_next got busy=%b valid=%b req=%b exp=0", m_busy, m_valid, m_req);
        end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (m_done || m_busy) dones++;
            step();
        end
        checks++;
        if (dones != 0) begin errors++; $display("FAIL abort_no_done got=%0d active cycles exp=0", dones); end
        win_ack = 1'b0; out_ready = 1'b0;
        run_frame(3, 3, 1, 0, 0, 0, 0, dc, n, rl, st);
        checks++;
        if (n != 9 || dc != 28) begin
            errors++; $display("FAIL abort_restart got n=%0d done=%0d exp n=9 done=28", n, dc);
        end
    endtask

    task automatic test_start_busy();
        int unsigned dc, n, rl, st;
        do_reset(0);
        run_frame(3, 3, 1, 0, 0, 0, 10, dc, n, rl, st);
        checks++;
        if (n != 9 || dc != 28) begin
            errors++; $display("FAIL start_busy got n=%0d done=%0d exp n=9 done=28", n, dc);
        end
    endtask

    task automatic test_reset_mid();
        int unsigned act;
        do_reset(0);
        start = 1'b1; win_ack = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({m_busy, m_done, m_req, m_conv, m_valid} !== 5'b0 || m_wrow !== 8'd0 ||
            m_wcol !== 8'd0 || m_addr !== 16'd0) begin
            errors++; $display("FAIL reset_mid got=%b/%0d/%0d/%0d exp=0",
                               {m_busy, m_done, m_req, m_conv, m_valid}, m_wrow, m_wcol, m_addr);
        end
        act = 0;
        for (int i = 0; i < 40; i++) begin
            if (m_done || m_busy) act++;
            step();
        end
        checks++;
        if (act != 0) begin errors++; $display("FAIL reset_mid_quiet got=%0d active cycles exp=0", act); end
        win_ack = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_random_big();
        int unsigned dc, n, rl, st;
        do_reset(2);
        run_frame(26, 26, 1, 1, 0, 0, 0, dc, n, rl, st);
        checks++;
        if (n != 676) begin errors++; $display("FAIL big_count got=%0d exp=676", n); end
    endtask

    initial begin
        checks = 0; errors = 0; sel = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; win_ack = 1'b0; out_ready = 1'b0;
        test_reset();
        test_stride1();
        test_stride2();
        test_backpressure();
        test_abort();
        test_start_busy();
        test_reset_mid();
        test_random_big();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
